// File: rtl/hamming_tx.sv
// Hamming(7,4) serial transmitter; tx goes low 1 cycle after accept; in_ready only in IDLE, input ignored while busy.
// Optional overall-parity (SECDED) bit after the codeword when HAMMING_TX_SECDED_EN is defined.
module hamming_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

`ifdef HAMMING_TX_SECDED_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [7:0] LAST     = 8'(CLKS_PER_BIT - 1);
   localparam bit         ONE_CLK  = (CLKS_PER_BIT == 1);
   localparam logic [7:0] PRE_LAST = ONE_CLK ? 8'd0 : 8'(CLKS_PER_BIT - 2);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   logic [6:0] cw;

   // bit 0 is codeword position 1 (p1), bit 6 is position 7 (d3)
   function automatic logic [6:0] encode(input logic [3:0] d);
      encode = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   assign idx_nxt  = idx + 3'd1;
   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
         idx   <= 3'd0;
         cw    <= 7'd0;
         tx    <= 1'b1;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cw    <= encode(data_in);
                  state <= START;
                  tx    <= 1'b0;
                  cnt   <= 8'd0;
               end
            end
            START: begin
               if (cnt == LAST) begin
                  cnt   <= 8'd0;
                  idx   <= 3'd0;
                  state <= DATA;
                  tx    <= cw[0];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt <= 8'd0;
                  if (idx == 3'd6) begin
`ifdef HAMMING_TX_SECDED_EN
                     state <= PARITY;
                     tx    <= ^cw;
`else
                     state <= STOP;
                     tx    <= 1'b1;
                     done  <= ONE_CLK;
`endif
                  end else begin
                     idx <= idx_nxt;
                     tx  <= cw[idx_nxt];
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`ifdef HAMMING_TX_SECDED_EN
            PARITY: begin
               if (cnt == LAST) begin
                  cnt   <= 8'd0;
                  state <= STOP;
                  tx    <= 1'b1;
                  done  <= ONE_CLK;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`endif
            STOP: begin
               // done is registered, so it is raised one edge ahead of the final stop cycle
               if (cnt == LAST) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end else begin
                  cnt  <= cnt + 8'd1;
                  done <= (cnt == PRE_LAST);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_tx.sv
// Directed bench for hamming_tx: two instances (CLKS_PER_BIT 1 and 4) checked bit-by-bit against hand-computed codewords.
module tb_hamming_tx;

`ifdef HAMMING_TX_SECDED_EN
   localparam bit SECDED = 1'b1;
`else
   localparam bit SECDED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data1, data4;
   logic       valid1, valid4;
   logic       ready1, tx1, busy1, done1;
   logic       ready4, tx4, busy4, done4;
   logic       sel;
   logic       tx_s, ready_s, busy_s, done_s;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   hamming_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(data1), .in_valid(valid1),
      .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

   hamming_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(data4), .in_valid(valid4),
      .in_ready(ready4), .tx(tx4), .busy(busy4), .done(done4));

   assign tx_s    = sel ? tx4    : tx1;
   assign ready_s = sel ? ready4 : ready1;
   assign busy_s  = sel ? busy4  : busy1;
   assign done_s  = sel ? done4  : done1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
      end
   endtask

   task automatic set_in(input logic v, input logic [3:0] d);
      if (sel) begin
         valid4 = v;
         data4  = d;
      end else begin
         valid1 = v;
         data1  = d;
      end
   endtask

   // Called at posedge+1 with the selected DUT idle; returns at posedge+1 in the first idle cycle after the frame.
   task automatic run_frame(input logic [3:0] nib, input logic [6:0] cw, input logic p, input bit hold);
      int         cpb;
      int         nb;
      logic [9:0] bits;
      cpb  = sel ? 4 : 1;
      nb   = SECDED ? 10 : 9;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 7; i++) bits[i+1] = cw[i];
      if (SECDED) bits[8] = p;
      check("ready_before", 32'(ready_s), 32'd1);
      set_in(1'b1, nib);
      @(posedge clk); #1;
      if (!hold) set_in(1'b0, ~nib);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < cpb; c++) begin
            check("tx", 32'(tx_s), 32'(bits[b]));
            check("busy", 32'(busy_s), 32'd1);
            check("in_ready", 32'(ready_s), 32'd0);
            check("done", 32'(done_s), 32'((b == nb - 1) && (c == cpb - 1)));
            if (hold) begin
               if ((b == nb - 1) && (c == cpb - 1)) set_in(1'b0, nib);
               else set_in(1'b1, 4'($urandom));
            end
            @(posedge clk); #1;
         end
      end
      check("ready_after", 32'(ready_s), 32'd1);
      check("busy_after", 32'(busy_s), 32'd0);
      check("tx_idle", 32'(tx_s), 32'd1);
      check("done_after", 32'(done_s), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      sel    = 1'b0;
      valid1 = 1'b0;
      valid4 = 1'b0;
      data1  = 4'd0;
      data4  = 4'd0;
      #12;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_tx", 32'(tx_s), 32'd1);
         check("rst_ready", 32'(ready_s), 32'd1);
         check("rst_busy", 32'(busy_s), 32'd0);
         check("rst_done", 32'(done_s), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // CLKS_PER_BIT = 1
      sel = 1'b0;
      run_frame(4'b1011, 7'b1010101, 1'b0, 1'b0);
      run_frame(4'b0110, 7'b0110011, 1'b0, 1'b0);
      run_frame(4'b0001, 7'b0000111, 1'b1, 1'b1);

      // CLKS_PER_BIT = 4, including back-to-back 1111 then 0000
      sel = 1'b1;
      run_frame(4'b0001, 7'b0000111, 1'b1, 1'b0);
      run_frame(4'b1111, 7'b1111111, 1'b1, 1'b0);
      run_frame(4'b0000, 7'b0000000, 1'b0, 1'b0);
      run_frame(4'b0110, 7'b0110011, 1'b0, 1'b1);

      // reset during data bit index 3 (position 4, value 0 for nibble 0001)
      set_in(1'b1, 4'b0001);
      @(posedge clk); #1;
      set_in(1'b0, 4'd0);
      repeat (17) @(posedge clk);
      #1;
      check("pre_rst_tx", 32'(tx4), 32'd0);
      check("pre_rst_busy", 32'(busy4), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx4), 32'd1);
      check("mid_rst_ready", 32'(ready4), 32'd1);
      check("mid_rst_busy", 32'(busy4), 32'd0);
      check("mid_rst_done", 32'(done4), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("post_rst_tx", 32'(tx4), 32'd1);
         check("post_rst_done", 32'(done4), 32'd0);
         check("post_rst_ready", 32'(ready4), 32'd1);
         @(posedge clk); #1;
      end
      run_frame(4'b1011, 7'b1010101, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hamming_tx.md
HAMMING_TX -- requirements
Module: hamming_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held on tx; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 data_in  input  4  nibble to encode; bit 0 = d0.
REQ-005 in_valid  input  1  data_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a nibble this cycle.
REQ-007 tx  output  1  serial line; idle level is 1.
REQ-008 busy  output  1  a frame is in progress.
REQ-009 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 The block SHALL accept a nibble when in_valid and in_ready are both 1 on a rising edge, and SHALL latch data_in at that edge; later data_in changes SHALL NOT affect the frame.
REQ-011 The block SHALL compute Hamming(7,4) positions 1..7 as p1, p2, d0, p4, d1, d2, d3, where p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE->START on acceptance.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY (SECDED_EN) or DATA->STOP after 7 bits.
- PARITY->STOP after one bit.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 tx SHALL be 1 in IDLE, 0 in START, and codeword positions 1..7 in order (position 1 first) in DATA.
- In PARITY, tx SHALL carry the overall parity bit.
- In STOP, tx SHALL be 1.
REQ-014 Each bit SHALL be held exactly CLKS_PER_BIT cycles, counted by a bit-period counter that restarts at each bit boundary.
REQ-015 tx SHALL go to 0 in the first cycle after the accepting edge, giving a latency of 1 cycle.
REQ-016 Frame length SHALL be 9*CLKS_PER_BIT cycles, or 10*CLKS_PER_BIT cycles with SECDED_EN.
REQ-017 in_ready SHALL be 1 only in IDLE, and busy SHALL be the exact complement of in_ready.
REQ-018 in_valid asserted while busy SHALL be ignored; no queueing.
REQ-019 done SHALL pulse high for exactly the last cycle of STOP, and in_ready SHALL rise in the following cycle.
- A nibble presented then SHALL start the next frame with no idle bit between frames.
REQ-020 CLKS_PER_BIT=1 SHALL produce one bit per cycle with no skipped or repeated bits.

Reset
REQ-021 While rst_n=0, outputs SHALL be:
- tx=1, in_ready=1, busy=0, done=0.
- FSM in IDLE; counters and latched codeword cleared.
REQ-022 A reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and return tx to 1, with no partial stop bit or done pulse.
REQ-023 The first acceptance after deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-024 Macro HAMMING_TX_SECDED_EN:
- When defined, the PARITY state SHALL be compiled in, transmitting p0 = XOR of positions 1..7 (even overall parity, SECDED).
- When undefined, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-025 CLKS_PER_BIT=1, no macro, data_in=4'b1011 accepted -> tx sequence 0,1,0,1,0,1,0,1,1, done at cycle 9, in_ready high at cycle 10.
REQ-026 CLKS_PER_BIT=4, SECDED_EN, data_in=4'b0001 -> tx = 0, then 1,1,1,0,0,0,0, then parity 1, then stop 1, each held 4 cycles; frame length 40 cycles.
REQ-027 SECDED_EN, data_in=4'b1111 then 4'b0000 back-to-back -> first codeword 1111111 with p0=1, second all zeros with p0=0, no idle gap.
REQ-028 in_valid held high with data_in toggling during a frame -> only the nibble at acceptance is sent; in_ready=0 and busy=1 throughout.
REQ-029 rst_n pulsed low during DATA bit 3 -> tx=1 within the same cycle, no done pulse, in_ready=1 after release; the next frame is correct.
